// File: rtl/wb_write_buffer.sv
// rtl/wb_write_buffer.sv - write-back FIFO with registered register-file port and pending-write forwarding
module wb_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_dest,
    input  logic [31:0]              in_data,
    input  logic                     wb_hold,
    output logic [3:0]               Dest_wb,
    output logic [31:0]              Result_WB,
    output logic                     writeBackEn,
    input  logic [3:0]               fwd_src1,
    input  logic [3:0]               fwd_src2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [31:0]              fwd_data1,
    output logic [31:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pc_write_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] PC_IDX = 4'd15;

    logic [3:0]    dest_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !wb_hold;

    always_ff @(posedge clk) begin
        if (rst && push) begin
            dest_mem[wr_ptr] <= in_dest;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            writeBackEn  <= 1'b0;
            Dest_wb      <= '0;
            Result_WB    <= '0;
            pc_write_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // PC-targeted entries drain silently and leave the port untouched
            writeBackEn <= pop && (dest_mem[rd_ptr] != PC_IDX);
            if (pop && (dest_mem[rd_ptr] != PC_IDX)) begin
                Dest_wb   <= dest_mem[rd_ptr];
                Result_WB <= data_mem[rd_ptr];
            end
            if (push && (in_dest == PC_IDX)) begin
                pc_write_err <= 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the last match (tail-most) wins
    function automatic logic [32:0] fwd_lookup(input logic [3:0] src);
        logic [32:0]   res;
        logic [AW-1:0] idx;
        res = '0;
        if (writeBackEn && (Dest_wb == src)) begin
            res = {1'b1, Result_WB};
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((CW'(i) < count) && (dest_mem[idx] == src)) begin
                res = {1'b1, data_mem[idx]};
            end
        end
        if (src == PC_IDX) begin
            res = '0;
        end
        return res;
    endfunction

    always_comb begin
        {fwd_hit1, fwd_data1} = fwd_lookup(fwd_src1);
        {fwd_hit2, fwd_data2} = fwd_lookup(fwd_src2);
    end

endmodule

// File: tb/tb_wb_write_buffer.sv
// tb/tb_wb_write_buffer.sv - scoreboard bench for wb_write_buffer
module tb_wb_write_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_dest;
    logic [31:0] in_data;
    logic        wb_hold;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic        writeBackEn;
    logic [3:0]  fwd_src1;
    logic [3:0]  fwd_src2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [$clog2(DEPTH):0] count;
    logic        pc_write_err;

    int          n_checks;
    int          n_errors;
    int          wb_pulses;
    logic [35:0] sb [$];

    wb_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dest     (in_dest),
        .in_data     (in_data),
        .wb_hold     (wb_hold),
        .Dest_wb     (Dest_wb),
        .Result_WB   (Result_WB),
        .writeBackEn (writeBackEn),
        .fwd_src1    (fwd_src1),
        .fwd_src2    (fwd_src2),
        .fwd_hit1    (fwd_hit1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2),
        .count       (count),
        .pc_write_err(pc_write_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one entry for one edge; the entry is expected back only if it was accepted
    task automatic drive(input logic [3:0] d, input logic [31:0] x, output bit acc);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = x;
        acc      = in_ready;
        if (acc && (d != 4'd15)) begin
            sb.push_back({d, x});
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (writeBackEn === 1'b1) begin
            wb_pulses++;
            if (sb.size() == 0) begin
                check("unexpected_wb", 1, 0);
            end else begin
                check("wb_entry", {Dest_wb, Result_WB}, sb.pop_front());
            end
        end
    end

    initial begin
        bit          acc;
        int          nacc;
        int          snap;
        logic [31:0] r;

        n_checks  = 0;
        n_errors  = 0;
        wb_pulses = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_dest   = '0;
        in_data   = '0;
        wb_hold   = 1'b0;
        fwd_src1  = 4'd0;
        fwd_src2  = 4'd0;

        repeat (2) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_wben", writeBackEn, 0);
        check("rst_dest", Dest_wb, 0);
        check("rst_result", Result_WB, 0);
        check("rst_pcerr", pc_write_err, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        // Single write with minimum latency
        drive(4'd3, 32'hDEADBEEF, acc);
        check("sw_acc", acc, 1);
        check("sw_pre_wben", writeBackEn, 0);
        check("sw_count", count, 1);
        @(negedge clk);
        check("sw_wben", writeBackEn, 1);
        check("sw_dest", Dest_wb, 3);
        check("sw_result", Result_WB, 32'hDEADBEEF);
        @(negedge clk);
        check("sw_post_wben", writeBackEn, 0);
        check("sw_hold_dest", Dest_wb, 3);

        // Fill under hold, then drain in order
        wb_hold = 1'b1;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(4'(8 + i), $urandom, acc);
            nacc += int'(acc);
        end
        check("fill_accepted", nacc, 4);
        check("fill_ready", in_ready, 0);
        check("fill_count", count, 4);
        snap = wb_pulses;
        wb_hold = 1'b0;
        @(negedge clk);
        check("fill_ready_after_pop", in_ready, 1);
        check("fill_count_after_pop", count, 3);
        repeat (4) @(negedge clk);
        check("fill_pulses", wb_pulses - snap, 4);
        check("fill_sb_empty", sb.size(), 0);

        // Forwarding priority: youngest FIFO entry, then output register
        wb_hold = 1'b1;
        drive(4'd2, 32'h11, acc);
        drive(4'd2, 32'h22, acc);
        fwd_src1 = 4'd2;
        fwd_src2 = 4'd7;
        #1;
        check("fwd_hit1", fwd_hit1, 1);
        check("fwd_data1", fwd_data1, 32'h22);
        check("fwd_hit2", fwd_hit2, 0);
        check("fwd_data2", fwd_data2, 0);
        wb_hold = 1'b0;
        @(negedge clk);
        #1;
        check("fwd_mixed_data", fwd_data1, 32'h22);
        @(negedge clk);
        #1;
        check("fwd_outreg_wben", writeBackEn, 1);
        check("fwd_outreg_hit", fwd_hit1, 1);
        check("fwd_outreg_data", fwd_data1, 32'h22);
        @(negedge clk);
        #1;
        check("fwd_gone_hit", fwd_hit1, 0);
        check("fwd_gone_data", fwd_data1, 0);

        // Write to PC index
        wb_hold = 1'b1;
        drive(4'd15, 32'h100, acc);
        check("pc_acc", acc, 1);
        check("pc_err", pc_write_err, 1);
        check("pc_count", count, 1);
        fwd_src1 = 4'd15;
        #1;
        check("pc_fwd_hit", fwd_hit1, 0);
        check("pc_fwd_data", fwd_data1, 0);
        wb_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("pc_drained", count, 0);
        check("pc_sticky", pc_write_err, 1);

        // Streaming push+pop at count 2 across pointer wraparound
        wb_hold = 1'b1;
        drive(4'($urandom_range(14, 0)), $urandom, acc);
        drive(4'($urandom_range(14, 0)), $urandom, acc);
        check("stream_prefill", count, 2);
        wb_hold = 1'b0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            r = $urandom;
            drive(4'($urandom_range(14, 0)), r, acc);
            check("stream_acc", acc, 1);
            check("stream_count", count, 2);
        end
        repeat (4) @(negedge clk);
        check("stream_sb_empty", sb.size(), 0);

        // Reset with pending entries discards them; inputs ignored while in reset
        wb_hold = 1'b1;
        drive(4'd4, 32'hA4, acc);
        drive(4'd15, 32'hF0, acc);
        drive(4'd5, 32'hA5, acc);
        check("rst3_count", count, 3);
        check("rst3_pcerr", pc_write_err, 1);
        rst = 1'b0;
        sb.delete();
        in_valid = 1'b1;
        in_dest  = 4'd6;
        in_data  = 32'h66;
        snap = wb_pulses;
        @(negedge clk);
        check("rst3_count_clr", count, 0);
        check("rst3_wben", writeBackEn, 0);
        check("rst3_pcerr_clr", pc_write_err, 0);
        check("rst3_dest", Dest_wb, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        wb_hold  = 1'b0;
        repeat (4) @(negedge clk);
        check("rst3_no_stale", wb_pulses - snap, 0);
        check("rst3_count_after", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_write_buffer.md
WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of 2, 2..16).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  producer offers a write-back result this cycle.
REQ-005 in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 in_dest  input  4  destination register index.
REQ-007 in_data  input  32  result value.
REQ-008 wb_hold  input  1  when 1, suppresses draining.
REQ-009 Dest_wb  output  4  register-file write index, registered.
REQ-010 Result_WB  output  32  register-file write data, registered.
REQ-011 writeBackEn  output  1  register-file write strobe, registered, one cycle per entry.
REQ-012 fwd_src1, fwd_src2  input  4 each  forwarding lookup indices.
REQ-013 fwd_hit1, fwd_hit2  output  1 each  a pending write to that index exists.
REQ-014 fwd_data1, fwd_data2  output  32 each  youngest pending value for that index, 0 when no hit.
REQ-015 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 pc_write_err  output  1  sticky flag: an entry with in_dest = 15 was accepted.

Function
REQ-017 Accept (push) SHALL occur on a rising edge where in_valid && in_ready.
REQ-018 in_ready SHALL equal (count < DEPTH), from registered state only; no same-cycle push-through when full.
REQ-019 Entries SHALL be stored in a circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-020 Pop SHALL occur on a rising edge where count > 0 and wb_hold = 0; the head entry is loaded into Dest_wb/Result_WB and writeBackEn is set to 1 for the following cycle.
REQ-021 On a rising edge with no pop, writeBackEn SHALL be 0; Dest_wb and Result_WB SHALL hold their previous values.
REQ-022 Outputs SHALL change only on rising edges, so they are stable at the register file's falling-edge write.
REQ-023 Minimum latency: an entry accepted at edge N with an empty FIFO and wb_hold = 0 SHALL pop at edge N+1, writeBackEn high during cycle N+1..N+2.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 Entries with in_dest = 15 SHALL be accepted and SHALL consume a FIFO slot, but SHALL NOT assert writeBackEn when popped; pc_write_err SHALL set on acceptance and stay set until reset.
REQ-026 Forwarding SHALL be combinational over all valid FIFO entries plus the output register while writeBackEn = 1; the youngest match wins (FIFO tail-most, output register oldest).
REQ-027 Index 15 SHALL never produce a forwarding hit.
REQ-028 Entries written to the same index more than once SHALL all be written back in order; no coalescing.
REQ-029 wb_hold SHALL not block pushes; the FIFO fills to DEPTH, then in_ready = 0.

Reset
REQ-030 While rst = 0 at a rising edge: pointers and count = 0, writeBackEn = 0, Dest_wb = 0, Result_WB = 0, pc_write_err = 0; in_ready = 1 from the next cycle.
REQ-031 Reset mid-operation SHALL discard all pending entries without issuing writes; no writeBackEn in the cycle after a reset edge.
REQ-032 Inputs SHALL be ignored during any cycle rst = 0.

Verification
REQ-033 Single write: push (dest 3, 0xDEADBEEF), wb_hold = 0 -> next cycle writeBackEn = 1, Dest_wb = 3, Result_WB = 0xDEADBEEF, then writeBackEn = 0.
REQ-034 Fill under hold: wb_hold = 1, push 5 entries with DEPTH = 4 -> 4 accepted, in_ready = 0, count = 4; release hold -> 4 consecutive writes in push order, in_ready = 1 after first pop.
REQ-035 Forwarding priority: push (dest 2, 0x11) then (dest 2, 0x22) under hold; fwd_src1 = 2 -> fwd_hit1 = 1, fwd_data1 = 0x22; fwd_src2 = 7 -> fwd_hit2 = 0, fwd_data2 = 0.
REQ-036 PC write: push (dest 15, 0x100) -> pc_write_err = 1, count increments, no writeBackEn on pop, fwd hit on 15 = 0.
REQ-037 Simultaneous push/pop with count = 2 and wraparound over 3*DEPTH entries -> count stays 2, write order matches push order.
REQ-038 Reset with 3 pending entries -> count = 0, writeBackEn = 0, no stale writes afterward, pc_write_err cleared.
